// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller for load/store buffer and instruction fetch
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback,
  input  logic              lsb_en,
  input  logic              lsb_wr,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [2:0]        lsb_len,
  input  logic [31:0]       lsb_w_data,
  output logic              lsb_done,
  output logic [31:0]       lsb_r_data,
  input  logic              if_en,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t            state_q, state_d;
  logic [2:0]        k_q, k_d, len_q, len_d, n, k_inc;
  logic [1:0]        j;
  logic              own_q, own_d, pend_q, pend_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_a_q, mem_a_d;
  logic [31:0]       wdata_q, wdata_d, rbuf_q, rbuf_d, lsb_r_data_q, lsb_r_data_d, if_data_q, if_data_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d, lsb_done_q, lsb_done_d, if_done_q, if_done_d;
  logic              pend_keep, active_lsb, accept, cand, gated;
  assign lsb_done   = lsb_done_q;
  assign lsb_r_data = lsb_r_data_q;
  assign if_done    = if_done_q;
  assign if_data    = if_data_q;
  assign mem_dout   = mem_dout_q;
  assign mem_a      = mem_a_q;
  assign mem_wr     = mem_wr_q;
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    own_d        = own_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    rbuf_d       = rbuf_q;
    lsb_r_data_d = lsb_r_data_q;
    if_data_d    = if_data_q;
    lsb_done_d   = 1'b0;
    if_done_d    = 1'b0;
    // rollback flushes speculative loads; committed stores survive it
    pend_keep    = pend_q && !(rollback && !wr_q);
    active_lsb   = state_q != IDLE && !own_q && !(rollback && state_q == READ);
    accept       = lsb_en && !pend_keep && !active_lsb;
    addr_d       = accept ? lsb_addr : addr_q;
    wr_d         = accept ? lsb_wr : wr_q;
    len_d        = accept ? lsb_len : len_q;
    wdata_d      = accept ? lsb_w_data : wdata_q;
    cand         = accept || pend_keep;
    pend_d       = cand;
    gated        = wr_d && addr_d[17:16] == 2'b11 && io_buffer_full;
    n            = own_q ? 3'd4 : len_q;
    k_inc        = k_q + 3'd1;
    j            = k_q[1:0] - 2'd1;
    case (state_q)
      IDLE: begin
        if (cand && !gated) begin
          pend_d     = 1'b0;
          own_d      = 1'b0;
          k_d        = 3'd0;
          mem_a_d    = addr_d;
          rbuf_d     = '0;
          mem_wr_d   = wr_d;
          mem_dout_d = wdata_d[7:0];
          state_d    = wr_d ? WRITE : READ;
        end else if (!cand && if_en && !rollback) begin
          own_d   = 1'b1;
          k_d     = 3'd0;
          mem_a_d = if_addr;
          rbuf_d  = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (rollback) begin
          state_d  = IDLE;
          mem_wr_d = 1'b0;
        end else begin
          // k counts edges since start; byte k-1 arrives from the registered RAM
          k_d = k_inc;
          if (k_inc < n) mem_a_d = mem_a_q + ADDR_W'(1);
          if (k_q != 3'd0) rbuf_d[{j, 3'b000} +: 8] = mem_din;
          if (k_q == n) begin
            state_d      = IDLE;
            if_done_d    = own_q;
            lsb_done_d   = !own_q;
            if_data_d    = own_q ? rbuf_d : if_data_q;
            lsb_r_data_d = own_q ? lsb_r_data_q : rbuf_d;
          end
        end
      end
      WRITE: begin
        if (k_inc < len_q) begin
          k_d        = k_inc;
          mem_a_d    = mem_a_q + ADDR_W'(1);
          mem_dout_d = wdata_q[{k_inc[1:0], 3'b000} +: 8];
        end else begin
          mem_wr_d   = 1'b0;
          lsb_done_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      len_q        <= '0;
      own_q        <= 1'b0;
      pend_q       <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      mem_a_q      <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      lsb_r_data_q <= '0;
      if_data_q    <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      lsb_done_q   <= 1'b0;
      if_done_q    <= 1'b0;
    end else if (rdy) begin
      state_q      <= state_d;
      k_q          <= k_d;
      len_q        <= len_d;
      own_q        <= own_d;
      pend_q       <= pend_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      mem_a_q      <= mem_a_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      lsb_r_data_q <= lsb_r_data_d;
      if_data_q    <= if_data_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      lsb_done_q   <= lsb_done_d;
      if_done_q    <= if_done_d;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized scoreboard bench for mem_ctrl with a byte-array reference memory
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy, rollback, lsb_en, lsb_wr, if_en, io_buffer_full;
  logic [31:0] lsb_addr, lsb_w_data, if_addr;
  logic [2:0]  lsb_len;
  logic        lsb_done, if_done, mem_wr;
  logic [31:0] lsb_r_data, if_data, mem_a;
  logic [7:0]  mem_din, mem_dout;
  int          checks = 0, errors = 0, wr_cnt = 0;
  typedef struct {bit ld; logic [31:0] d;} ent_t;
  ent_t        lq[$];
  logic [31:0] fq[$];
  logic [7:0]  refm[logic [31:0]];
  logic [7:0]  ram [0:262143];
  bit          wrt [0:262143];
  bit          rand_on;
  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data),
    .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] init_b(logic [31:0] a);
    return (a[7:0] * 8'd7) ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'h3c;
  endfunction
  function automatic logic [7:0] ram_rd(logic [31:0] a);
    return wrt[a[17:0]] ? ram[a[17:0]] : init_b(a);
  endfunction
  function automatic logic [7:0] ref_rd(logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_b(a);
  endfunction
  function automatic logic [31:0] ref_load(logic [31:0] a, logic [2:0] len);
    logic [31:0] v = '0;
    for (int i = 0; i < int'(len); i++) v[8*i +: 8] = ref_rd(a + 32'(i));
    return v;
  endfunction
  // RAM with a one-cycle registered read, frozen together with the controller
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram_rd(mem_a);
      if (mem_wr) begin
        ram[mem_a[17:0]] <= mem_dout;
        wrt[mem_a[17:0]] <= 1'b1;
      end
    end
  end
  always @(negedge clk) if (mem_wr) wr_cnt <= wr_cnt + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (lsb_done || if_done) chk("done_exclusive", 32'(lsb_done & if_done), 32'd0);
      if (lsb_done) begin
        if (lq.size() == 0) chk("unexpected_lsb_done", 32'd1, 32'd0);
        else begin
          e = lq.pop_front();
          if (e.ld) chk("lsb_r_data", lsb_r_data, e.d);
        end
      end
      if (if_done) begin
        if (fq.size() == 0) chk("unexpected_if_done", 32'd1, 32'd0);
        else chk("if_data", if_data, fq.pop_front());
      end
    end
  end
  task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] len, input logic [31:0] d);
    ent_t e;
    lsb_en = 1'b1; lsb_wr = wr; lsb_addr = a; lsb_len = len; lsb_w_data = d;
    e.ld = !wr;
    e.d = ref_load(a, len);
    lq.push_back(e);
    if (wr) for (int i = 0; i < int'(len); i++) refm[a + 32'(i)] = d[8*i +: 8];
  endtask
  task automatic run_lsb(input logic wr, input logic [31:0] a, input logic [2:0] len, input logic [31:0] d, output int lat);
    issue(wr, a, len, d);
    @(negedge clk);
    lsb_en = 1'b0;
    lat = 0;
    while (!lsb_done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("lsb_done_seen", 32'(lsb_done), 32'd1);
  endtask
  task automatic track(input int max, input int lsb_at, input logic [31:0] a, input logic [2:0] len,
                       output int t_l, output int t_i);
    t_l = -1; t_i = -1;
    for (int n = 1; n <= max; n++) begin
      @(negedge clk);
      lsb_en = 1'b0;
      if (lsb_done && t_l < 0) t_l = n;
      if (if_done && t_i < 0) begin t_i = n; if_en = 1'b0; end
      if (n == lsb_at) issue(1'b0, a, len, 32'h0);
    end
  endtask
  initial begin
    int lat, t_l, t_i, n, w0;
    logic [31:0] d;
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; lsb_en = 1'b0; lsb_wr = 1'b0; if_en = 1'b0;
    io_buffer_full = 1'b0; lsb_addr = '0; lsb_w_data = '0; if_addr = '0; lsb_len = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_ctl", 32'({mem_wr, lsb_done, if_done, mem_dout}), 32'd0);
    chk("rst_data", lsb_r_data | if_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_lsb(1'b1, 32'h1000, 3'd4, 32'h44332211, lat);
    chk("sw_latency", lat, 4);
    run_lsb(1'b0, 32'h1000, 3'd4, 32'h0, lat);
    chk("lw_latency", lat, 5);
    chk("lw_value", lsb_r_data, 32'h44332211);
    run_lsb(1'b0, 32'h1003, 3'd1, 32'h0, lat);
    chk("lb_latency", lat, 2);
    chk("lb_value", lsb_r_data, 32'h44);
    w0 = wr_cnt;
    run_lsb(1'b1, 32'h2002, 3'd2, 32'hDEADBEEF, lat);
    chk("sh_latency", lat, 2);
    @(negedge clk);
    chk("sh_mem_wr_cycles", wr_cnt - w0, 2);
    chk("sh_ram_2002", 32'(ram_rd(32'h2002)), 32'hEF);
    chk("sh_ram_2003", 32'(ram_rd(32'h2003)), 32'hBE);
    chk("sh_ram_2004", 32'(ram_rd(32'h2004)), 32'(init_b(32'h2004)));
    run_lsb(1'b0, 32'hFFFFFFFE, 3'd4, 32'h0, lat);
    chk("wrap_latency", lat, 5);
    if_en = 1'b1; if_addr = 32'h0; fq.push_back(ref_load(32'h0, 3'd4));
    issue(1'b0, 32'h1000, 3'd4, 32'h0);
    track(16, -1, 32'h0, 3'd0, t_l, t_i);
    chk("prio_lsb_time", t_l, 6);
    chk("prio_if_time", t_i, 12);
    if_en = 1'b1; if_addr = 32'h4; fq.push_back(ref_load(32'h4, 3'd4));
    track(12, 2, 32'h1001, 3'd1, t_l, t_i);
    chk("fetch_then_lsb_if", t_i, 6);
    chk("fetch_then_lsb_lsb", t_l, 9);
    if_en = 1'b1; if_addr = 32'h8; t_i = -1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      rollback = 1'b0;
      if (if_done && t_i < 0) begin t_i = k; if_en = 1'b0; end
      if (k == 3) begin rollback = 1'b1; if_en = 1'b0; end
      if (k == 4) begin if_en = 1'b1; if_addr = 32'hC; fq.push_back(ref_load(32'hC, 3'd4)); end
    end
    chk("rollback_fetch_restart", t_i, 10);
    issue(1'b1, 32'h1104, 3'd4, 32'hA5C3_1E77);
    n = 0;
    while (!lsb_done && n < 40) begin
      @(negedge clk);
      lsb_en = 1'b0; rollback = 1'b0; n++;
      if (n == 2) rollback = 1'b1;
    end
    chk("rollback_sw_done", n, 5);
    run_lsb(1'b0, 32'h1104, 3'd4, 32'h0, lat);
    w0 = wr_cnt;
    io_buffer_full = 1'b1; if_en = 1'b1; if_addr = 32'h10; fq.push_back(ref_load(32'h10, 3'd4));
    d = $urandom;
    issue(1'b1, 32'h30000, 3'd1, d);
    t_l = -1; t_i = -1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      lsb_en = 1'b0;
      if (k <= 3) chk("io_gate_no_wr", 32'(mem_wr), 32'd0);
      if (k == 3) io_buffer_full = 1'b0;
      if (lsb_done && t_l < 0) t_l = k;
      if (if_done && t_i < 0) begin t_i = k; if_en = 1'b0; end
    end
    chk("io_gate_store_done", t_l, 5);
    chk("io_gate_fetch_done", t_i, 11);
    chk("io_gate_wr_cycles", wr_cnt - w0, 1);
    chk("io_gate_ram", 32'(ram_rd(32'h30000)), 32'(d[7:0]));
    issue(1'b0, 32'h1000, 3'd4, 32'h0);
    n = 0;
    while (!lsb_done && n < 40) begin
      @(negedge clk);
      lsb_en = 1'b0; n++;
      if (n == 3) rdy = 1'b0;
      if (n == 7) rdy = 1'b1;
    end
    chk("freeze_latency", n - 1, 9);
    chk("freeze_value", lsb_r_data, 32'h44332211);
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h1200; lsb_len = 3'd4; lsb_w_data = 32'h12345678;
    @(negedge clk); lsb_en = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mid_ctl", 32'({mem_a[7:0], lsb_done, if_done, mem_dout}), 32'd0);
    chk("rst_mid_data", lsb_r_data | if_data, 32'd0);
    repeat (8) @(negedge clk);
    rand_on = 1'b1;
    fork
      begin
        fork
          begin
            logic [2:0] lens [3] = '{3'd1, 3'd2, 3'd4};
            logic       wr;
            logic [31:0] a;
            int          rl;
            for (int i = 0; i < 150; i++) begin
              repeat ($urandom_range(0, 3)) @(negedge clk);
              wr = 1'($urandom % 2);
              a = ($urandom % 4 == 0) ? 32'h30000 + ($urandom % 16) : 32'h1000 + ($urandom % 256);
              run_lsb(wr, a, lens[$urandom % 3], $urandom, rl);
            end
          end
          begin
            int c;
            for (int i = 0; i < 60; i++) begin
              repeat ($urandom_range(0, 6)) @(negedge clk);
              if_en = 1'b1; if_addr = $urandom % 256;
              fq.push_back(ref_load(if_addr, 3'd4));
              c = 0;
              while (c < 400) begin
                @(negedge clk);
                c++;
                if (if_done) break;
              end
              chk("fetch_done_seen", 32'(if_done), 32'd1);
              if_en = 1'b0;
            end
          end
        join
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(negedge clk);
          io_buffer_full = ($urandom % 3 == 0);
        end
        io_buffer_full = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    chk("lsb_queue_drained", lq.size(), 0);
    chk("if_queue_drained", fq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
